// File: rtl/mips_mult_wb_scheduler_pkg.sv
// Shared widths, defaults and record types for the multiplier writeback scheduler.
package mips_mult_wb_scheduler_pkg;
  localparam int REG_ADDR_W       = 5;
  localparam int DATA_W           = 32;
  localparam int MULT_LAT_DEF     = 4;
  localparam int WB_DEPTH_DEF     = 4;
  localparam int LIVELOCK_CYC_DEF = 16;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
  } t_mult_tag;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } t_wb_entry;
endpackage

// File: rtl/mips_mult_wb_scheduler_if.sv
// Decode/writeback-side signal bundle between the pipeline and the multiplier scheduler.
interface mips_mult_wb_scheduler_if;
  import mips_mult_wb_scheduler_pkg::*;

  logic                  issue_valid_D;
  logic                  issue_mult_D;
  logic                  reg_write_D;
  logic [REG_ADDR_W-1:0] src_a_addr_D;
  logic [REG_ADDR_W-1:0] src_b_addr_D;
  logic [REG_ADDR_W-1:0] dest_addr_D;
  logic [DATA_W-1:0]     mult_result_W;
  logic                  main_we_W;
  logic [REG_ADDR_W-1:0] main_waddr_W;
  logic [DATA_W-1:0]     main_wdata_W;
  logic                  mult_start_D;
  logic                  stall;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  livelock;

  modport master (
    output issue_valid_D, issue_mult_D, reg_write_D, src_a_addr_D, src_b_addr_D, dest_addr_D,
           mult_result_W, main_we_W, main_waddr_W, main_wdata_W,
    input  mult_start_D, stall, rf_we, rf_waddr, rf_wdata, livelock
  );

  modport slave (
    input  issue_valid_D, issue_mult_D, reg_write_D, src_a_addr_D, src_b_addr_D, dest_addr_D,
           mult_result_W, main_we_W, main_waddr_W, main_wdata_W,
    output mult_start_D, stall, rf_we, rf_waddr, rf_wdata, livelock
  );
endinterface

// File: rtl/mips_mult_wb_scheduler_wb_fifo.sv
// Small synchronous FIFO holding multiplier results displaced from the RF write port.
module mips_wb_fifo
  import mips_mult_wb_scheduler_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH_DEF,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  t_wb_entry        push_entry,
  input  logic             pop,
  output t_wb_entry        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  t_wb_entry        mem_q [DEPTH];
  t_wb_entry        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];
  assign do_pop = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/mips_mult_wb_scheduler.sv
// Multiplier issue/stall control and RF write-port arbitration between main pipe and mult results.
module mips_mult_wb_scheduler
  import mips_mult_wb_scheduler_pkg::*;
#(
  parameter int MULT_LAT     = MULT_LAT_DEF,
  parameter int WB_DEPTH     = WB_DEPTH_DEF,
  parameter int LIVELOCK_CYC = LIVELOCK_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  mips_mult_wb_scheduler_if.slave bus
);
  localparam int NREG   = 2 ** REG_ADDR_W;
  localparam int OUT_W  = $clog2(MULT_LAT + WB_DEPTH + 1);
  localparam int FCNT_W = $clog2(WB_DEPTH + 1);
  localparam int LL_W   = $clog2(LIVELOCK_CYC + 1);

  t_mult_tag             tag_q [MULT_LAT];
  t_mult_tag             tag_d [MULT_LAT];
  logic [NREG-1:0]       pending_q, pending_d;
  logic [LL_W-1:0]       ll_cnt_q, ll_cnt_d;
  logic                  rf_we_q, rf_we_d, rf_mult_q, rf_mult_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;

  logic [OUT_W-1:0]      inflight_cnt, outstanding;
  logic [FCNT_W-1:0]     fifo_cnt;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  t_wb_entry             fifo_head, fifo_in;
  t_mult_tag             exit_tag;
  logic                  exit_keep, raw, waw, cap, stall, mult_start;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < MULT_LAT; i++) inflight_cnt = inflight_cnt + OUT_W'(tag_q[i].valid);
  end

  assign outstanding = inflight_cnt + OUT_W'(fifo_cnt);
  assign raw = ((bus.src_a_addr_D != '0) && pending_q[bus.src_a_addr_D]) ||
               ((bus.src_b_addr_D != '0) && pending_q[bus.src_b_addr_D]);
  assign waw = (bus.issue_mult_D || bus.reg_write_D) && (bus.dest_addr_D != '0) &&
               pending_q[bus.dest_addr_D];
  assign cap = bus.issue_mult_D && (outstanding >= OUT_W'(WB_DEPTH));
  assign stall      = bus.issue_valid_D && (raw || waw || cap);
  assign mult_start = bus.issue_valid_D && bus.issue_mult_D && !stall;

  assign bus.stall        = stall;
  assign bus.mult_start_D = mult_start;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.livelock     = (ll_cnt_q == LL_W'(LIVELOCK_CYC));

  // r0 results still travel the tag pipe but are discarded at its exit.
  assign exit_tag  = tag_q[MULT_LAT-1];
  assign exit_keep = exit_tag.valid && (exit_tag.dest != '0);
  assign fifo_in   = '{dest: exit_tag.dest, data: bus.mult_result_W};

  always_comb begin
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    rf_we_d    = 1'b0;
    rf_mult_d  = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (bus.main_we_W) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.main_waddr_W;
      rf_wdata_d = bus.main_wdata_W;
      fifo_push  = exit_keep;
    end else if (!fifo_empty) begin
      fifo_pop   = 1'b1;
      rf_we_d    = 1'b1;
      rf_mult_d  = 1'b1;
      rf_waddr_d = fifo_head.dest;
      rf_wdata_d = fifo_head.data;
      fifo_push  = exit_keep;
    end else if (exit_keep) begin
      rf_we_d    = 1'b1;
      rf_mult_d  = 1'b1;
      rf_waddr_d = exit_tag.dest;
      rf_wdata_d = bus.mult_result_W;
    end
  end

  always_comb begin
    tag_d[0] = '0;
    if (mult_start) tag_d[0] = '{valid: 1'b1, dest: bus.dest_addr_D};
    for (int i = 1; i < MULT_LAT; i++) tag_d[i] = tag_q[i-1];

    pending_d = pending_q;
    if (rf_we_q && rf_mult_q) pending_d[rf_waddr_q] = 1'b0;
    if (mult_start && (bus.dest_addr_D != '0)) pending_d[bus.dest_addr_D] = 1'b1;
    pending_d[0] = 1'b0;

    ll_cnt_d = '0;
    if (stall) ll_cnt_d = (ll_cnt_q == LL_W'(LIVELOCK_CYC)) ? ll_cnt_q : ll_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MULT_LAT; i++) tag_q[i] <= '0;
      pending_q  <= '0;
      ll_cnt_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_mult_q  <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      tag_q      <= tag_d;
      pending_q  <= pending_d;
      ll_cnt_q   <= ll_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_mult_q  <= rf_mult_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

  mips_wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (fifo_push),
    .push_entry(fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_mips_mult_wb_scheduler.sv
// Directed vector bench for the multiplier writeback scheduler.
module tb_mips_mult_wb_scheduler;
  typedef struct {
    bit         rb;
    logic       iv, im, rw;
    logic [4:0] sa, sb, dst;
    logic       mwe;
    logic [4:0] mwa;
    logic       es, est, ewe;
    logic [4:0] ewa;
    logic [31:0] ewd;
    logic       ell;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   k       = 0;
  string ctx;

  always #5 clk = ~clk;

  mips_mult_wb_scheduler_if bus();

  mips_mult_wb_scheduler dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic vec_t v(bit rb, logic iv, logic im, logic rw, logic [4:0] sa, logic [4:0] sb,
                             logic [4:0] dst, logic mwe, logic [4:0] mwa, logic es, logic est,
                             logic ewe, logic [4:0] ewa, logic [31:0] ewd, logic ell);
    vec_t t;
    t.rb = rb; t.iv = iv; t.im = im; t.rw = rw; t.sa = sa; t.sb = sb; t.dst = dst;
    t.mwe = mwe; t.mwa = mwa; t.es = es; t.est = est; t.ewe = ewe; t.ewa = ewa;
    t.ewd = ewd; t.ell = ell;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s cyc%0d: got %h expected %h", ctx, nm, k, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.issue_valid_D = 1'b0; bus.issue_mult_D = 1'b0; bus.reg_write_D = 1'b0;
    bus.src_a_addr_D = '0; bus.src_b_addr_D = '0; bus.dest_addr_D = '0;
    bus.main_we_W = 1'b0; bus.main_waddr_W = '0;
    bus.main_wdata_W = 32'hAA00_0000; bus.mult_result_W = 32'hC000_0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst_livelock", 32'(bus.livelock), 32'd0);
    bus.issue_valid_D = 1'b1; bus.issue_mult_D = 1'b1; bus.dest_addr_D = 5'd8;
    bus.src_a_addr_D = 5'd8;
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_start", 32'(bus.mult_start_D), 32'd1);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    k = 0;
  endtask

  task automatic apply(input vec_t t);
    if (t.rb) do_reset();
    @(negedge clk);
    bus.issue_valid_D = t.iv; bus.issue_mult_D = t.im; bus.reg_write_D = t.rw;
    bus.src_a_addr_D = t.sa; bus.src_b_addr_D = t.sb; bus.dest_addr_D = t.dst;
    bus.main_we_W = t.mwe; bus.main_waddr_W = t.mwa;
    bus.main_wdata_W = 32'hAA00_0000 | 32'(k);
    bus.mult_result_W = 32'hC000_0000 | 32'(k);
    #1;
    chk("start", 32'(bus.mult_start_D), 32'(t.es));
    chk("stall", 32'(bus.stall), 32'(t.est));
    chk("rf_we", 32'(bus.rf_we), 32'(t.ewe));
    if (t.ewe) begin
      chk("rf_waddr", 32'(bus.rf_waddr), 32'(t.ewa));
      chk("rf_wdata", bus.rf_wdata, t.ewd);
    end
    chk("livelock", 32'(bus.livelock), 32'(t.ell));
    k++;
  endtask

  vec_t tbl[$];
  string tname[$];

  initial begin
    rst = 1'b1;
    drive_idle();

    // isolated mult r8: written at MULT_LAT+1, then a reader of r8 is free
    tbl.push_back(v(1,1,1,0,0,0,8,0,0, 1,0,0,0,0,0)); tname.push_back("iso");
    for (int i = 1; i <= 4; i++) begin
      tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0)); tname.push_back("iso");
    end
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,1,8,32'hC000_0004,0)); tname.push_back("iso");
    tbl.push_back(v(0,1,0,1,8,0,3,0,0, 0,0,0,0,0,0)); tname.push_back("iso");

    // RAW on r8 stalls cycles 1..5, add issues on 6
    tbl.push_back(v(1,1,1,0,0,0,8,0,0, 1,0,0,0,0,0)); tname.push_back("raw");
    for (int i = 1; i <= 4; i++) begin
      tbl.push_back(v(0,1,0,1,0,8,2,0,0, 0,1,0,0,0,0)); tname.push_back("raw");
    end
    tbl.push_back(v(0,1,0,1,0,8,2,0,0, 0,1,1,8,32'hC000_0004,0)); tname.push_back("raw");
    tbl.push_back(v(0,1,0,1,0,8,2,0,0, 0,0,0,0,0,0)); tname.push_back("raw");

    // main write collides with exit: main first, r8 from FIFO next cycle
    tbl.push_back(v(1,1,1,0,0,0,8,0,0, 1,0,0,0,0,0)); tname.push_back("coll");
    for (int i = 1; i <= 3; i++) begin
      tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0)); tname.push_back("coll");
    end
    tbl.push_back(v(0,0,0,0,0,0,0,1,5, 0,0,0,0,0,0)); tname.push_back("coll");
    tbl.push_back(v(0,1,0,1,8,0,2,0,0, 0,1,1,5,32'hAA00_0004,0)); tname.push_back("coll");
    tbl.push_back(v(0,1,0,1,8,0,2,0,0, 0,1,1,8,32'hC000_0004,0)); tname.push_back("coll");
    tbl.push_back(v(0,1,0,1,8,0,2,0,0, 0,0,0,0,0,0)); tname.push_back("coll");

    // capacity: r1..r4 with main port busy, 5th stalls; drain in order
    tbl.push_back(v(1,1,1,0,0,0,1,1,10, 1,0,0,0,0,0)); tname.push_back("cap");
    for (int i = 1; i <= 3; i++) begin
      tbl.push_back(v(0,1,1,0,0,0,5'(i+1),1,10, 1,0,1,10,32'hAA00_0000 | 32'(i-1),0));
      tname.push_back("cap");
    end
    for (int i = 4; i <= 6; i++) begin
      tbl.push_back(v(0,1,1,0,0,0,5,1,10, 0,1,1,10,32'hAA00_0000 | 32'(i-1),0));
      tname.push_back("cap");
    end
    tbl.push_back(v(0,1,1,0,0,0,5,0,0, 0,1,1,10,32'hAA00_0006,0)); tname.push_back("cap");
    tbl.push_back(v(0,1,1,0,0,0,5,0,0, 1,0,1,1,32'hC000_0004,0)); tname.push_back("cap");
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,1,2,32'hC000_0005,0)); tname.push_back("cap");
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,1,3,32'hC000_0006,0)); tname.push_back("cap");
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,1,4,32'hC000_0007,0)); tname.push_back("cap");
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0)); tname.push_back("cap");
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,1,5,32'hC000_000C,0)); tname.push_back("cap");

    // mult to r0: never written, never blocks
    tbl.push_back(v(1,1,1,0,0,0,0,0,0, 1,0,0,0,0,0)); tname.push_back("r0");
    tbl.push_back(v(0,1,0,1,0,0,7,0,0, 0,0,0,0,0,0)); tname.push_back("r0");
    tbl.push_back(v(0,1,1,0,0,0,0,0,0, 1,0,0,0,0,0)); tname.push_back("r0");
    for (int i = 3; i <= 7; i++) begin
      tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0)); tname.push_back("r0");
    end

    // WAW on r9 until the mult result lands
    tbl.push_back(v(1,1,1,0,0,0,9,0,0, 1,0,0,0,0,0)); tname.push_back("waw");
    for (int i = 1; i <= 4; i++) begin
      tbl.push_back(v(0,1,0,1,1,1,9,0,0, 0,1,0,0,0,0)); tname.push_back("waw");
    end
    tbl.push_back(v(0,1,0,1,1,1,9,0,0, 0,1,1,9,32'hC000_0004,0)); tname.push_back("waw");
    tbl.push_back(v(0,1,0,1,1,1,9,0,0, 0,0,0,0,0,0)); tname.push_back("waw");

    foreach (tbl[i]) begin
      ctx = tname[i];
      apply(tbl[i]);
    end

    // reset with three mults in flight discards them all
    ctx = "midrst";
    do_reset();
    for (int i = 0; i < 3; i++) apply(v(0,1,1,0,0,0,5'(i+1),0,0, 1,0,0,0,0,0));
    do_reset();
    for (int i = 0; i < 8; i++) apply(v(0,1,0,1,1,2,3,0,0, 0,0,0,0,0,0));

    // RAW held behind a busy write port long enough to flag livelock
    ctx = "livelock";
    apply(v(1,1,1,0,0,0,8,1,4, 1,0,0,0,0,0));
    for (int i = 1; i <= 21; i++) begin
      logic ewe;
      logic [4:0] ewa;
      logic [31:0] ewd;
      ewe = (i <= 19);
      ewa = (i == 19) ? 5'd8 : 5'd4;
      ewd = (i == 19) ? 32'hC000_0004 : (32'hAA00_0000 | 32'(i - 1));
      apply(v(0,1,0,1,8,0,2,(i <= 17),4, 0,(i <= 19),ewe,ewa,ewd,(i >= 17 && i <= 20)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
